// File: rtl/npu_img_row_loader.sv
// Row feeder for the NPU AHB slave: buffers byte-serial RGB pixels, writes each full row as AHB
// byte writes, then commits the row. Define NPU_IMG_ROW_LOADER_RESULT_POLL_EN to poll for the class.
module npu_img_row_loader #(
  parameter int          ROW_BYTES  = 84,
  parameter int          IMG_ROWS   = 28,
  parameter int          FIFO_DEPTH = 128,
  parameter logic [31:0] MEM_BASE   = 32'h4000_0000,
  parameter logic [31:0] CTRL_ADDR  = 32'h4000_1000,
  parameter logic [31:0] STAT_ADDR  = 32'h4000_1004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_data_i,
  output logic        pix_ready_o,
  output logic [31:0] ahb_m_haddr_o,
  output logic        ahb_m_hwrite_o,
  output logic [2:0]  ahb_m_hsize_o,
  output logic [1:0]  ahb_m_htrans_o,
  output logic [31:0] ahb_m_hwdata_o,
  input  logic        ahb_m_hready_i,
  input  logic        ahb_m_hresp_i,
  input  logic [31:0] ahb_m_hrdata_i,
  output logic [5:0]  row_cnt_o,
  output logic        frame_done_p_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        class_valid_p_o,
  output logic [4:0]  class_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WDATA,
    S_CADDR,
    S_CDATA,
    S_ERR
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
    ,
    S_PADDR,
    S_PDATA
`endif
  } state_t;

  state_t state, state_n;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;

  logic [6:0]  col;
  logic [5:0]  row_cnt;
  logic [31:0] hwdata_q;
  logic        err_q;
  logic        frame_done_q;

  logic        in_data, err_hit, fifo_full, push, pop;
  logic        row_avail, last_col, last_row, commit;
  logic [31:0] byte_addr;

  // Any data phase can take an error response; the transfer is dropped and the row abandoned.
  always_comb begin
    in_data = 1'b0;
    case (state)
      S_WDATA, S_CDATA: in_data = 1'b1;
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
      S_PDATA:          in_data = 1'b1;
`endif
      default:          in_data = 1'b0;
    endcase
  end

  assign err_hit   = in_data & ahb_m_hresp_i;
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push      = pix_valid_i & pix_ready_o;
  assign pop       = (state == S_WADDR) & ahb_m_hready_i;
  assign row_avail = (fifo_cnt >= CNT_W'(ROW_BYTES));
  assign last_col  = (col == 7'(ROW_BYTES - 1));
  assign last_row  = (row_cnt == 6'(IMG_ROWS - 1));
  assign commit    = (state == S_CDATA) & ahb_m_hready_i & ~ahb_m_hresp_i;
  assign byte_addr = MEM_BASE + 32'(row_cnt) * 32'(ROW_BYTES) + 32'(col);

  assign pix_ready_o    = ~fifo_full & (state != S_ERR);
  assign ahb_m_hwdata_o = hwdata_q;
  assign row_cnt_o      = row_cnt;
  assign frame_done_p_o = frame_done_q;
  assign err_o          = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n        = state;
    ahb_m_htrans_o = HTRANS_IDLE;
    ahb_m_hwrite_o = 1'b0;
    ahb_m_hsize_o  = HSIZE_BYTE;
    ahb_m_haddr_o  = '0;
    case (state)
      S_IDLE: begin
        if (row_avail) state_n = S_WADDR;
      end
      S_WADDR: begin
        ahb_m_htrans_o = HTRANS_NONSEQ;
        ahb_m_hwrite_o = 1'b1;
        ahb_m_hsize_o  = HSIZE_BYTE;
        ahb_m_haddr_o  = byte_addr;
        if (ahb_m_hready_i) state_n = S_WDATA;
      end
      S_WDATA: begin
        if (ahb_m_hready_i) state_n = last_col ? S_CADDR : S_WADDR;
      end
      S_CADDR: begin
        ahb_m_htrans_o = HTRANS_NONSEQ;
        ahb_m_hwrite_o = 1'b1;
        ahb_m_hsize_o  = HSIZE_WORD;
        ahb_m_haddr_o  = CTRL_ADDR;
        if (ahb_m_hready_i) state_n = S_CDATA;
      end
      S_CDATA: begin
        if (ahb_m_hready_i) begin
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
          state_n = last_row ? S_PADDR : S_IDLE;
`else
          state_n = S_IDLE;
`endif
        end
      end
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
      S_PADDR: begin
        ahb_m_htrans_o = HTRANS_NONSEQ;
        ahb_m_hwrite_o = 1'b0;
        ahb_m_hsize_o  = HSIZE_WORD;
        ahb_m_haddr_o  = STAT_ADDR;
        if (ahb_m_hready_i) state_n = S_PDATA;
      end
      S_PDATA: begin
        if (ahb_m_hready_i) state_n = ahb_m_hrdata_i[0] ? S_IDLE : S_PADDR;
      end
`endif
      S_ERR: begin
        if (err_clr_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (err_hit) state_n = S_ERR;
  end

  // NOTE: the pixel storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= pix_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every register sees
    // pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (err_hit) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // hwdata is loaded on address acceptance and then held for the whole data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      row_cnt      <= '0;
      hwdata_q     <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= commit & last_row;
      if (pop)
        hwdata_q <= {4{fifo_mem[rd_ptr]}};
      else if ((state == S_CADDR) && ahb_m_hready_i)
        hwdata_q <= 32'h1;

      if (err_hit)
        col <= '0;
      else if ((state == S_IDLE) && row_avail)
        col <= '0;
      else if ((state == S_WDATA) && ahb_m_hready_i)
        col <= col + 7'd1;

      if (commit) row_cnt <= last_row ? 6'd0 : row_cnt + 6'd1;

      if (err_hit)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
  logic [4:0] class_q;
  logic       class_valid_q;
  logic       unused_hrdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_q       <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= 1'b0;
      if ((state == S_PDATA) && ahb_m_hready_i && !ahb_m_hresp_i && ahb_m_hrdata_i[0]) begin
        class_q       <= ahb_m_hrdata_i[8:4];
        class_valid_q <= 1'b1;
      end
    end
  end

  assign class_o         = class_q;
  assign class_valid_p_o = class_valid_q;
  assign unused_hrdata   = ^{ahb_m_hrdata_i[31:9], ahb_m_hrdata_i[3:1]};
`else
  logic unused_hrdata;

  assign class_o         = '0;
  assign class_valid_p_o = 1'b0;
  assign unused_hrdata   = ^ahb_m_hrdata_i;
`endif

endmodule

// File: tb/tb_npu_img_row_loader.sv
// Self-checking bench for npu_img_row_loader: a row-vector table drives an AHB slave model whose
// accepted transfers are compared against a scoreboard of expected transfers.
module tb_npu_img_row_loader;

  localparam int          ROW_BYTES = 84;
  localparam int          IMG_ROWS  = 28;
  localparam logic [31:0] MEM_BASE  = 32'h4000_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h4000_1000;
  localparam logic [31:0] STAT_ADDR = 32'h4000_1004;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    int         start;
    int         stall;
    int         err_byte;
    logic [5:0] row_after;
    logic       err_after;
  } row_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_data = '0;
  logic        pix_ready;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic [5:0]  row_cnt;
  logic        frame_done;
  logic        err;
  logic        err_clr = 1'b0;
  logic        class_valid;
  logic [4:0]  class_val;

  npu_img_row_loader dut (
    .clk             (clk),
    .rst             (rst),
    .pix_valid_i     (pix_valid),
    .pix_data_i      (pix_data),
    .pix_ready_o     (pix_ready),
    .ahb_m_haddr_o   (haddr),
    .ahb_m_hwrite_o  (hwrite),
    .ahb_m_hsize_o   (hsize),
    .ahb_m_htrans_o  (htrans),
    .ahb_m_hwdata_o  (hwdata),
    .ahb_m_hready_i  (hready),
    .ahb_m_hresp_i   (hresp),
    .ahb_m_hrdata_i  (hrdata),
    .row_cnt_o       (row_cnt),
    .frame_done_p_o  (frame_done),
    .err_o           (err),
    .err_clr_i       (err_clr),
    .class_valid_p_o (class_valid),
    .class_o         (class_val)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  xfer_t       sb[$];
  logic [31:0] stat_q[$];
  bit          sb_en = 1'b1;
  int          stall_pct = 0;
  bit          err_armed = 1'b0;
  logic [31:0] err_addr = '0;
  int          n_wr = 0;
  int          n_reads = 0;
  int          mdl_row = 0;

  // AHB slave model: hready/hresp/hrdata are chosen on the falling edge for the next rising edge.
  bit          dp_valid = 1'b0, dp_first = 1'b0, dp_write = 1'b0, ap_stalled = 1'b0;
  logic [31:0] dp_addr, dp_hwdata, ap_addr;
  logic [2:0]  dp_size;

  always @(negedge clk) begin
    if (rst) begin
      dp_valid   = 1'b0;
      ap_stalled = 1'b0;
      hready     = 1'b1;
      hresp      = 1'b0;
      hrdata     = '0;
    end else begin
      hresp  = 1'b0;
      hrdata = '0;
      hready = (int'($urandom_range(99)) >= stall_pct);
      if (dp_valid) begin
        if (dp_first) dp_hwdata = hwdata;
        else if (dp_write) check("hwdata_hold", hwdata, dp_hwdata);
        dp_first = 1'b0;
        if (hready) begin
          if (!dp_write) begin
            n_reads++;
            if (stat_q.size() != 0) hrdata = stat_q.pop_front();
          end else begin
            n_wr++;
          end
          if (err_armed && dp_addr == err_addr) begin
            hresp     = 1'b1;
            err_armed = 1'b0;
          end
          if (sb_en) begin
            if (sb.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL sb_unexpected: got addr %h write %0b, expected no transfer", dp_addr, dp_write);
            end else begin
              xfer_t e;
              e = sb.pop_front();
              check("haddr", dp_addr, e.addr);
              check("hwrite", 32'(dp_write), 32'(e.wr));
              check("hsize", 32'(dp_size), 32'(e.size));
              if (e.wr) check("hwdata", hwdata, e.data);
            end
          end
          dp_valid = 1'b0;
        end
      end else if (htrans == 2'b10) begin
        if (ap_stalled) check("haddr_hold", haddr, ap_addr);
        if (hready) begin
          dp_valid   = 1'b1;
          dp_first   = 1'b1;
          dp_addr    = haddr;
          dp_write   = hwrite;
          dp_size    = hsize;
          ap_stalled = 1'b0;
        end else begin
          ap_stalled = 1'b1;
          ap_addr    = haddr;
        end
      end
    end
  end

  int          cyc = 0;
  int          t_start = 0, t_commit = 0;
  int          n_frame = 0, n_class = 0;
  logic [4:0]  class_seen = '0;
  logic [31:0] row_first_addr = '0;
  logic [5:0]  last_row_cnt = '0;
  bit          busy_row = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      busy_row     = 1'b0;
      last_row_cnt = '0;
    end else begin
      if (frame_done) n_frame++;
      if (class_valid) begin
        n_class++;
        class_seen = class_val;
      end
      if (err) busy_row = 1'b0;
      else if (htrans == 2'b10 && hsize == 3'b000 && !busy_row) begin
        busy_row       = 1'b1;
        t_start        = cyc;
        row_first_addr = haddr;
      end
      if (row_cnt != last_row_cnt) begin
        t_commit     = cyc;
        busy_row     = 1'b0;
        last_row_cnt = row_cnt;
      end
    end
  end

  task automatic push_pixels(input int n, input int start, input logic [31:0] base, input int n_exp);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      int g;
      b = 8'(start + k);
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = b;
      g = 0;
      while (!pix_ready && g < 2000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 2000) begin
        $display("FAIL pix_ready_timeout: got ready 0 expected 1 at byte %0d", k);
        $fatal(1, "pixel stream stuck");
      end
      if (k < n_exp) sb.push_back('{base + 32'(k), 1'b1, 3'b000, {4{b}}});
    end
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while ((sb.size() != 0 || dp_valid || htrans != 2'b00) && g < 20000);
    if (g >= 20000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending transfers expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_row(input row_vec_t v);
    logic [31:0] base;
    int          n_exp;
    bit          last;
    base  = MEM_BASE + 32'(mdl_row) * 32'(ROW_BYTES);
    n_exp = (v.err_byte >= 0) ? v.err_byte + 1 : ROW_BYTES;
    last  = (mdl_row == IMG_ROWS - 1) && (v.err_byte < 0);
    stall_pct = v.stall;
    if (v.err_byte >= 0) begin
      err_addr  = base + 32'(v.err_byte);
      err_armed = 1'b1;
    end
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
    if (last) begin
      stat_q.push_back(32'h0);
      stat_q.push_back(32'h0);
      stat_q.push_back(32'h0);
      stat_q.push_back(32'h0000_0071);
    end
`endif
    push_pixels(ROW_BYTES, v.start, base, n_exp);
    if (v.err_byte < 0) begin
      sb.push_back('{CTRL_ADDR, 1'b1, 3'b010, 32'h1});
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
      if (last) for (int i = 0; i < 4; i++) sb.push_back('{STAT_ADDR, 1'b0, 3'b010, 32'h0});
`endif
      mdl_row = last ? 0 : mdl_row + 1;
    end
    wait_idle();
    check("row_cnt", 32'(row_cnt), 32'(v.row_after));
    check("err_o", 32'(err), 32'(v.err_after));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_vec_t vecs[4];
    vecs[0] = '{start: 0,   stall: 0,  err_byte: -1, row_after: 6'd1, err_after: 1'b0};
    vecs[1] = '{start: 0,   stall: 30, err_byte: -1, row_after: 6'd2, err_after: 1'b0};
    vecs[2] = '{start: 100, stall: 0,  err_byte: 10, row_after: 6'd2, err_after: 1'b1};
    vecs[3] = '{start: 17,  stall: 0,  err_byte: -1, row_after: 6'd3, err_after: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_hwdata", hwdata, 32'h0);
    check("rst_hsize", 32'(hsize), 32'h0);
    check("rst_hwrite", 32'(hwrite), 32'h0);
    check("rst_row_cnt", 32'(row_cnt), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_class_valid", 32'(class_valid), 32'h0);
    check("rst_class", 32'(class_val), 32'h0);
    check("rst_pix_ready", 32'(pix_ready), 32'h1);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      apply_row(vecs[i]);
      if (i == 0) check("row0_cycles", 32'(t_commit - t_start), 32'd170);
      if (i == 2) begin
        check("err_ready", 32'(pix_ready), 32'h0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_cleared", 32'(err), 32'h0);
        check("ready_after_clr", 32'(pix_ready), 32'h1);
        check("row_cnt_after_clr", 32'(row_cnt), 32'd2);
      end
      if (i == 3) check("row2_base", row_first_addr, 32'h4000_00A8);
    end
    check("no_frame_yet", 32'(n_frame), 32'd0);

    for (int r = 3; r < IMG_ROWS; r++)
      apply_row('{start: r * 5, stall: (r % 2 == 1) ? 10 : 0, err_byte: -1,
                  row_after: 6'((r + 1) % IMG_ROWS), err_after: 1'b0});
    check("last_row_base", row_first_addr, 32'h4000_08DC);
    check("frame_pulses", 32'(n_frame), 32'd1);
`ifdef NPU_IMG_ROW_LOADER_RESULT_POLL_EN
    check("status_reads", 32'(n_reads), 32'd4);
    check("class_pulses", 32'(n_class), 32'd1);
    check("class_value", 32'(class_seen), 32'd7);
    check("class_held", 32'(class_val), 32'd7);
`else
    check("status_reads", 32'(n_reads), 32'd0);
    check("class_pulses", 32'(n_class), 32'd0);
    check("class_value", 32'(class_val), 32'd0);
`endif

    // Reset in the middle of a row, while the bus is in a byte-write data phase.
    sb_en     = 1'b0;
    stall_pct = 0;
    n_wr      = 0;
    push_pixels(ROW_BYTES, 8'h40, MEM_BASE, 0);
    begin
      int g;
      g = 0;
      do begin
        @(negedge clk);
        #1;
        g++;
      end while (!(dp_valid && dp_write && n_wr >= 40) && g < 2000);
      if (g >= 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL wdata_timeout: got %0d writes expected 40", n_wr);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    check("arst_htrans", 32'(htrans), 32'h0);
    check("arst_haddr", haddr, 32'h0);
    check("arst_hwrite", 32'(hwrite), 32'h0);
    check("arst_hsize", 32'(hsize), 32'h0);
    check("arst_hwdata", hwdata, 32'h0);
    check("arst_row_cnt", 32'(row_cnt), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    check("arst_pix_ready", 32'(pix_ready), 32'h1);
    check("arst_frame_done", 32'(frame_done), 32'h0);
    check("arst_class_valid", 32'(class_valid), 32'h0);
    check("arst_class", 32'(class_val), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stat_q.delete();
    sb_en   = 1'b1;
    mdl_row = 0;
    apply_row('{start: 200, stall: 20, err_byte: -1, row_after: 6'd1, err_after: 1'b0});
    check("post_rst_base", row_first_addr, MEM_BASE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
